// File: rtl/pixel_pkg.sv
// Shared constants and the loader state type for the SPI pixel loader.
package pixel_pkg;

  localparam int unsigned NUM_PIXEL_BYTES = 72;
  localparam int unsigned BYTE_W          = 8;
  localparam int unsigned COUNT_W         = 7;

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StFull
  } loader_state_e;

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchroniser for one asynchronous SPI line, with edge detection
// on the synchronised level.
module spi_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic n_rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Synchroniser chain plus one extra flop holding the previous synced level.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_pixel_loader.sv
// SPI (mode 0, MSB first) byte receiver feeding the pixel shift register.
// Optional build macro SPI_PIXEL_ECHO_EN: echoes the previous accepted byte on miso.
module spi_pixel_loader
  import pixel_pkg::*;
#(
  parameter int unsigned NUM_BYTES   = NUM_PIXEL_BYTES,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               sck,
  input  logic               mosi,
  input  logic               ss_n,
  output logic               miso,
  input  logic               network_calc,
  input  logic               clear_img,
  output logic [BYTE_W-1:0]  spi_in,
  output logic               shift_SPI,
  output logic               write_en,
  output logic [COUNT_W-1:0] byte_count,
  output logic               image_ready,
  output logic               overrun
);

  localparam logic [COUNT_W-1:0] CountMax = COUNT_W'(NUM_BYTES);
  localparam logic [COUNT_W-1:0] CountOne = COUNT_W'(1);

  logic sck_level, sck_rise, sck_fall;
  logic ss_level, ss_rise, ss_fall;

  spi_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b0)
  ) u_sck_sync (
    .clk   (clk),
    .n_rst (n_rst),
    .din   (sck),
    .level (sck_level),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  // Select idles high, so a frame already open at reset shows up as a fall.
  spi_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b1)
  ) u_ss_sync (
    .clk   (clk),
    .n_rst (n_rst),
    .din   (ss_n),
    .level (ss_level),
    .rise  (ss_rise),
    .fall  (ss_fall)
  );

  // Edge outputs not every build needs; kept on a sink to document the choice.
  logic unused_sync;
  assign unused_sync = ^{sck_level, sck_fall, ss_rise};

  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   mosi_s;

  // Plain synchroniser for mosi, same depth so data lines up with sck_rise.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      mosi_q <= '0;
    end else begin
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
    end
  end

  assign mosi_s = mosi_q[SYNC_STAGES-1];

  loader_state_e      state_q, state_d;
  logic [BYTE_W-1:0]  asm_q, asm_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic               byte_done_q, byte_done_d;
  logic [BYTE_W-1:0]  spi_in_q, spi_in_d;
  logic               shift_q, shift_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               overrun_q, overrun_d;
  logic               byte_take, accept, drop, last_byte;

  // Bit assembly: shift on synced sck rise while selected; deselect or clear
  // throws away any partial byte.
  always_comb begin
    asm_d       = asm_q;
    bit_cnt_d   = bit_cnt_q;
    byte_done_d = 1'b0;
    if (clear_img || ss_level) begin
      bit_cnt_d = '0;
    end else if (sck_rise) begin
      asm_d       = {asm_q[BYTE_W-2:0], mosi_s};
      bit_cnt_d   = bit_cnt_q + 3'd1;
      byte_done_d = (bit_cnt_q == 3'd7);
    end
  end

  // Acceptance, counters and next state; a clear always beats a completing byte.
  always_comb begin
    byte_take = byte_done_q & ~clear_img;
    accept    = byte_take & (state_q != StFull) & ~network_calc & (count_q < CountMax);
    drop      = byte_take & ~accept;
    last_byte = accept & (count_q == CountMax - CountOne);

    spi_in_d  = accept ? asm_q : spi_in_q;
    shift_d   = accept;
    count_d   = count_q;
    overrun_d = overrun_q | drop;
    if (clear_img) begin
      count_d   = '0;
      overrun_d = 1'b0;
    end else if (accept) begin
      count_d = count_q + CountOne;
    end

    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (last_byte)    state_d = StFull;
        else if (ss_fall) state_d = StRecv;
      end
      StRecv: begin
        if (last_byte)     state_d = StFull;
        else if (ss_level) state_d = StIdle;
      end
      StFull: begin
        if (clear_img) state_d = ss_level ? StIdle : StRecv;
      end
      default: state_d = StIdle;
    endcase
  end

  // Loader state and datapath registers.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q     <= StIdle;
      asm_q       <= '0;
      bit_cnt_q   <= '0;
      byte_done_q <= 1'b0;
      spi_in_q    <= '0;
      shift_q     <= 1'b0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      asm_q       <= asm_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_done_q <= byte_done_d;
      spi_in_q    <= spi_in_d;
      shift_q     <= shift_d;
      count_q     <= count_d;
      overrun_q   <= overrun_d;
    end
  end

  assign spi_in      = spi_in_q;
  assign shift_SPI   = shift_q;
  assign byte_count  = count_q;
  assign overrun     = overrun_q;
  assign image_ready = (count_q == CountMax);
  assign write_en    = (state_q == StRecv) & ~network_calc;

`ifdef SPI_PIXEL_ECHO_EN
  logic [BYTE_W-1:0] echo_q, echo_d;
  logic              miso_q, miso_d;

  // Echo: load the last accepted byte on a byte's first bit, shift out on falls.
  always_comb begin
    echo_d = echo_q;
    miso_d = miso_q;
    if (ss_level) begin
      miso_d = 1'b0;
    end else if (sck_rise && (bit_cnt_q == 3'd0)) begin
      echo_d = spi_in_q;
    end else if (sck_fall) begin
      miso_d = echo_q[BYTE_W-1];
      echo_d = {echo_q[BYTE_W-2:0], 1'b0};
    end
  end

  // Echo shift register and miso output flop.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      echo_q <= '0;
      miso_q <= 1'b0;
    end else begin
      echo_q <= echo_d;
      miso_q <= miso_d;
    end
  end

  assign miso = miso_q;
`else
  assign miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_pixel_loader.sv
// Directed bench for spi_pixel_loader; SCK runs at clk/8.
module tb_spi_pixel_loader;

  localparam int unsigned NB   = 72;
  localparam int unsigned SYNC = 2;

  logic       clk = 1'b0;
  logic       n_rst, sck, mosi, ss_n, miso, network_calc, clear_img;
  logic [7:0] spi_in;
  logic       shift_SPI, write_en, image_ready, overrun;
  logic [6:0] byte_count;

  int checks   = 0;
  int errors   = 0;
  int pulses   = 0;
  int miso_bad = 0;
  int lat      = -1;

  spi_pixel_loader #(
    .NUM_BYTES   (NB),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .sck          (sck),
    .mosi         (mosi),
    .ss_n         (ss_n),
    .miso         (miso),
    .network_calc (network_calc),
    .clear_img    (clear_img),
    .spi_in       (spi_in),
    .shift_SPI    (shift_SPI),
    .write_en     (write_en),
    .byte_count   (byte_count),
    .image_ready  (image_ready),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (shift_SPI === 1'b1) pulses++;
    if (miso !== 1'b0) miso_bad++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  task automatic do_reset;
    n_rst = 1'b0; ss_n = 1'b1; sck = 1'b0; mosi = 1'b0;
    network_calc = 1'b0; clear_img = 1'b0;
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic frame_start;
    ss_n = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  // Sends the top n bits of b, MSB first; leaves sck high after the last bit.
  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      mosi = b[i];
      sck  = 1'b0;
      repeat (4) @(negedge clk);
      sck = 1'b1;
      lat = -1;
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        if (shift_SPI === 1'b1 && lat < 0) lat = k;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 8);
    sck = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset;
    do_reset;
    checks++; if (spi_in !== 8'h00) begin errors++;
      $display("FAIL reset_spi_in: got %h expected 00", spi_in); end
    checks++; if (shift_SPI !== 1'b0) begin errors++;
      $display("FAIL reset_shift: got %b expected 0", shift_SPI); end
    checks++; if (write_en !== 1'b0) begin errors++;
      $display("FAIL reset_write_en: got %b expected 0", write_en); end
    checks++; if (byte_count !== 7'd0) begin errors++;
      $display("FAIL reset_count: got %0d expected 0", byte_count); end
    checks++; if (image_ready !== 1'b0) begin errors++;
      $display("FAIL reset_ready: got %b expected 0", image_ready); end
    checks++; if (overrun !== 1'b0) begin errors++;
      $display("FAIL reset_overrun: got %b expected 0", overrun); end
    checks++; if (miso !== 1'b0) begin errors++;
      $display("FAIL reset_miso: got %b expected 0", miso); end
  endtask

  task automatic test_single;
    int base;
    do_reset;
    frame_start;
    checks++; if (write_en !== 1'b1) begin errors++;
      $display("FAIL single_write_en_open: got %b expected 1", write_en); end
    base = pulses;
    send_byte(8'hA5);
    checks++; if (pulses - base !== 1) begin errors++;
      $display("FAIL single_pulses: got %0d expected 1", pulses - base); end
    checks++; if (lat !== int'(SYNC) + 2) begin errors++;
      $display("FAIL single_latency: got %0d expected %0d", lat, SYNC + 2); end
    checks++; if (spi_in !== 8'hA5) begin errors++;
      $display("FAIL single_spi_in: got %h expected a5", spi_in); end
    checks++; if (byte_count !== 7'd1) begin errors++;
      $display("FAIL single_count: got %0d expected 1", byte_count); end
    checks++; if (write_en !== 1'b1) begin errors++;
      $display("FAIL single_write_en: got %b expected 1", write_en); end
    ss_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (write_en !== 1'b0) begin errors++;
      $display("FAIL single_write_en_closed: got %b expected 0", write_en); end
    checks++; if (spi_in !== 8'hA5) begin errors++;
      $display("FAIL single_spi_in_held: got %h expected a5", spi_in); end
  endtask

  task automatic test_full_image;
    int base;
    do_reset;
    frame_start;
    base = pulses;
    for (int i = 0; i < int'(NB); i++) send_byte(8'(i));
    checks++; if (pulses - base !== int'(NB)) begin errors++;
      $display("FAIL full_pulses: got %0d expected %0d", pulses - base, NB); end
    checks++; if (image_ready !== 1'b1) begin errors++;
      $display("FAIL full_ready: got %b expected 1", image_ready); end
    checks++; if (byte_count !== 7'd72) begin errors++;
      $display("FAIL full_count: got %0d expected 72", byte_count); end
    checks++; if (spi_in !== 8'h47) begin errors++;
      $display("FAIL full_spi_in: got %h expected 47", spi_in); end
    checks++; if (write_en !== 1'b0) begin errors++;
      $display("FAIL full_write_en: got %b expected 0", write_en); end
    send_byte(8'hFF);
    checks++; if (pulses - base !== int'(NB)) begin errors++;
      $display("FAIL extra_pulses: got %0d expected %0d", pulses - base, NB); end
    checks++; if (overrun !== 1'b1) begin errors++;
      $display("FAIL extra_overrun: got %b expected 1", overrun); end
    checks++; if (spi_in !== 8'h47) begin errors++;
      $display("FAIL extra_spi_in: got %h expected 47", spi_in); end
    checks++; if (byte_count !== 7'd72) begin errors++;
      $display("FAIL extra_count: got %0d expected 72", byte_count); end
    // Clear while still selected returns to receiving.
    clear_img = 1'b1;
    @(negedge clk);
    clear_img = 1'b0;
    @(negedge clk);
    checks++; if (byte_count !== 7'd0) begin errors++;
      $display("FAIL fclear_count: got %0d expected 0", byte_count); end
    checks++; if (image_ready !== 1'b0) begin errors++;
      $display("FAIL fclear_ready: got %b expected 0", image_ready); end
    checks++; if (overrun !== 1'b0) begin errors++;
      $display("FAIL fclear_overrun: got %b expected 0", overrun); end
    checks++; if (write_en !== 1'b1) begin errors++;
      $display("FAIL fclear_write_en: got %b expected 1", write_en); end
  endtask

  task automatic test_partial;
    int base;
    do_reset;
    frame_start;
    base = pulses;
    send_bits(8'b1011_0000, 5);
    sck = 1'b0;
    repeat (4) @(negedge clk);
    ss_n = 1'b1;
    repeat (6) @(negedge clk);
    frame_start;
    send_byte(8'h3C);
    checks++; if (spi_in !== 8'h3C) begin errors++;
      $display("FAIL partial_spi_in: got %h expected 3c", spi_in); end
    checks++; if (byte_count !== 7'd1) begin errors++;
      $display("FAIL partial_count: got %0d expected 1", byte_count); end
    checks++; if (pulses - base !== 1) begin errors++;
      $display("FAIL partial_pulses: got %0d expected 1", pulses - base); end
  endtask

  task automatic test_network_calc;
    int base;
    do_reset;
    frame_start;
    send_byte(8'h22);
    base = pulses;
    network_calc = 1'b1;
    @(negedge clk);
    checks++; if (write_en !== 1'b0) begin errors++;
      $display("FAIL netcalc_write_en: got %b expected 0", write_en); end
    send_byte(8'h11);
    checks++; if (pulses - base !== 0) begin errors++;
      $display("FAIL netcalc_pulses: got %0d expected 0", pulses - base); end
    checks++; if (overrun !== 1'b1) begin errors++;
      $display("FAIL netcalc_overrun: got %b expected 1", overrun); end
    checks++; if (spi_in !== 8'h22) begin errors++;
      $display("FAIL netcalc_spi_in: got %h expected 22", spi_in); end
    network_calc = 1'b0;
    clear_img = 1'b1;
    @(negedge clk);
    clear_img = 1'b0;
    @(negedge clk);
    checks++; if (byte_count !== 7'd0) begin errors++;
      $display("FAIL netclear_count: got %0d expected 0", byte_count); end
    checks++; if (overrun !== 1'b0) begin errors++;
      $display("FAIL netclear_overrun: got %b expected 0", overrun); end
    checks++; if (write_en !== 1'b1) begin errors++;
      $display("FAIL netclear_write_en: got %b expected 1", write_en); end
  endtask

  task automatic test_clear_collision;
    int base;
    do_reset;
    frame_start;
    send_byte(8'h33);
    base = pulses;
    send_bits(8'h44, 7);
    mosi = 1'b0;
    sck  = 1'b0;
    repeat (4) @(negedge clk);
    sck = 1'b1;
    // Lands clear_img on the edge where the completed byte would be taken.
    repeat (SYNC + 1) @(negedge clk);
    clear_img = 1'b1;
    @(negedge clk);
    clear_img = 1'b0;
    repeat (2) @(negedge clk);
    sck = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (pulses - base !== 0) begin errors++;
      $display("FAIL collide_pulses: got %0d expected 0", pulses - base); end
    checks++; if (byte_count !== 7'd0) begin errors++;
      $display("FAIL collide_count: got %0d expected 0", byte_count); end
    checks++; if (overrun !== 1'b0) begin errors++;
      $display("FAIL collide_overrun: got %b expected 0", overrun); end
    checks++; if (spi_in !== 8'h33) begin errors++;
      $display("FAIL collide_spi_in: got %h expected 33", spi_in); end
  endtask

  task automatic test_reset_mid_byte;
    do_reset;
    frame_start;
    send_byte(8'h77);
    send_bits(8'h55, 4);
    sck   = 1'b0;
    n_rst = 1'b0;
    @(negedge clk);
    checks++; if (spi_in !== 8'h00) begin errors++;
      $display("FAIL midrst_spi_in: got %h expected 00", spi_in); end
    checks++; if (byte_count !== 7'd0) begin errors++;
      $display("FAIL midrst_count: got %0d expected 0", byte_count); end
    checks++; if (write_en !== 1'b0 || shift_SPI !== 1'b0) begin errors++;
      $display("FAIL midrst_ctrl: got %b%b expected 00", write_en, shift_SPI); end
    n_rst = 1'b1;
    repeat (6) @(negedge clk);
    send_byte(8'h66);
    checks++; if (spi_in !== 8'h66) begin errors++;
      $display("FAIL midrst_next_byte: got %h expected 66", spi_in); end
    checks++; if (byte_count !== 7'd1) begin errors++;
      $display("FAIL midrst_next_count: got %0d expected 1", byte_count); end
  endtask

  task automatic test_echo;
    logic [7:0] exp_echo;
    logic [7:0] second;
    int         bad_before;
    exp_echo = 8'h5A;
    second   = 8'hC3;
    do_reset;
    bad_before = miso_bad;
    frame_start;
    send_byte(8'h5A);
    for (int i = 7; i >= 0; i--) begin
      mosi = second[i];
      sck  = 1'b0;
      repeat (4) @(negedge clk);
`ifdef SPI_PIXEL_ECHO_EN
      if (i < 7) begin
        checks++; if (miso !== exp_echo[i+1]) begin errors++;
          $display("FAIL echo_bit%0d: got %b expected %b", i + 1, miso, exp_echo[i+1]); end
      end
`else
      checks++; if (miso !== 1'b0) begin errors++;
        $display("FAIL miso_tied_bit%0d: got %b expected 0", i, miso); end
`endif
      sck = 1'b1;
      repeat (4) @(negedge clk);
    end
    sck = 1'b0;
    repeat (4) @(negedge clk);
`ifdef SPI_PIXEL_ECHO_EN
    checks++; if (miso !== exp_echo[0]) begin errors++;
      $display("FAIL echo_bit0: got %b expected %b", miso, exp_echo[0]); end
`else
    checks++; if (miso_bad - bad_before !== 0) begin errors++;
      $display("FAIL miso_tied_run: got %0d nonzero samples expected 0",
               miso_bad - bad_before); end
`endif
    repeat (4) @(negedge clk);
    checks++; if (spi_in !== 8'hC3) begin errors++;
      $display("FAIL echo_spi_in: got %h expected c3", spi_in); end
    ss_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (miso !== 1'b0) begin errors++;
      $display("FAIL echo_deselect: got %b expected 0", miso); end
  endtask

  initial begin
    n_rst = 1'b0; ss_n = 1'b1; sck = 1'b0; mosi = 1'b0;
    network_calc = 1'b0; clear_img = 1'b0;
    test_reset;
    test_single;
    test_full_image;
    test_partial;
    test_network_calc;
    test_clear_collision;
    test_reset_mid_byte;
    test_echo;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
